// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, multi-cycle mul/div stall, branch flush, load-use stall.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_muldiv_start,
    input  logic        muldiv_done,
    input  logic        br_taken,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        muldiv_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e state_q, state_d;
    logic   mem_stall;
    logic   load_use;
    logic   md_active;

    always_comb begin
        mem_stall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
        load_use  = ex_mem_read & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        // A mul/div owns the pipe from the cycle it reaches EX until done.
        md_active = (state_q == BUSY) | ex_muldiv_start;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ex_muldiv_start & ~muldiv_done & ~mem_stall) state_d = BUSY;
            BUSY: if (muldiv_done & ~mem_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (rst | mem_stall) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (md_active & ~muldiv_done) begin
            // Hold front end; drain older work and feed bubbles into MEM.
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            load_id_ex   = 1'b0;
            flush_ex_mem = 1'b1;
        end else if (md_active) begin
            // Result handoff cycle: everything advances, nothing flushed.
        end else if (br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
        end
    end

    assign muldiv_busy = ~rst & (state_q == BUSY);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q,  flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (~load_pc & (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (flush_if_id & (flush_count_q != 32'hFFFF_FFFF))
            flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expected control vectors flow through a scoreboard queue.
// Counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req, imem_resp, dmem_req, dmem_resp;
    logic        ex_mem_read;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        ex_muldiv_start, muldiv_done, br_taken;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic        muldiv_busy;
    logic [31:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    //  flush_if_id, flush_id_ex, flush_ex_mem, muldiv_busy}
    logic [8:0]  exp_q[$];
    logic [63:0] cnt_q[$];
    logic [8:0]  obs;

    localparam logic [8:0] FREEZE = 9'b00000_000_0;
    localparam logic [8:0] ALL    = 9'b11111_000_0;
    localparam logic [8:0] MD     = 9'b00011_001_0;
    localparam logic [8:0] BRV    = 9'b11111_110_0;
    localparam logic [8:0] LU     = 9'b00111_010_0;
    localparam logic [8:0] BUSYB  = 9'b00000_000_1;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
    localparam logic [31:0] EXP_FLUSH = 32'd3;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

    assign obs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, muldiv_busy};

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_resp       (imem_resp),
        .dmem_req        (dmem_req),
        .dmem_resp       (dmem_resp),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_muldiv_start (ex_muldiv_start),
        .muldiv_done     (muldiv_done),
        .br_taken        (br_taken),
        .load_pc         (load_pc),
        .load_if_id      (load_if_id),
        .load_id_ex      (load_id_ex),
        .load_ex_mem     (load_ex_mem),
        .load_mem_wb     (load_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_ex_mem    (flush_ex_mem),
        .muldiv_busy     (muldiv_busy),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic clear_inputs();
        imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        ex_muldiv_start = 0; muldiv_done = 0; br_taken = 0;
    endtask

    // Push expectation, compare at negedge, then advance one clock.
    task automatic step(input string tag, input logic [8:0] exp);
        logic [8:0] got, e;
        exp_q.push_back(exp);
        @(negedge clk);
        got = obs;
        e = exp_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] es, input logic [31:0] ef);
        logic [63:0] got, e;
        cnt_q.push_back({es, ef});
        @(negedge clk);
        got = {stall_cycles, flush_count};
        e = cnt_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   tag, got[63:32], got[31:0], e[63:32], e[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        step("rst_outputs", FREEZE);
        ex_muldiv_start = 1; br_taken = 1;
        step("rst_gates_requests", FREEZE);
        clear_inputs();
        rst = 0;
        step("idle_default", ALL);

        // Instruction-memory wait with a pending branch: freeze, then flush on response
        imem_req = 1; imem_resp = 0; br_taken = 1;
        for (int i = 0; i < 3; i++) step("imem_freeze", FREEZE);
        imem_resp = 1;
        step("imem_resp_branch", BRV);
        clear_inputs();
        dmem_req = 1;
        step("dmem_freeze", FREEZE);
        dmem_resp = 1;
        step("dmem_resp", ALL);
        clear_inputs();

        // Load-use
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5;
        step("load_use_rs2", LU);
        id_rs2 = 0; id_rs1 = 5;
        step("load_use_rs1", LU);
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        step("load_use_x0", ALL);
        ex_rd = 5; id_rs1 = 5; ex_mem_read = 0;
        step("no_mem_read", ALL);
        clear_inputs();

        // Branch beats load-use
        br_taken = 1; ex_mem_read = 1; ex_rd = 7; id_rs1 = 7;
        step("branch_over_load_use", BRV);
        clear_inputs();

        // Mul/div: done at cycle 4
        ex_muldiv_start = 1;
        step("md_c0", MD);
        for (int i = 1; i < 4; i++) step("md_busy", MD | BUSYB);
        muldiv_done = 1;
        step("md_done", ALL | BUSYB);
        clear_inputs();
        step("md_idle", ALL);

        // Memory stall masks done while busy
        ex_muldiv_start = 1;
        step("md2_c0", MD);
        muldiv_done = 1; dmem_req = 1;
        step("md2_done_frozen", FREEZE | BUSYB);
        dmem_resp = 1;
        step("md2_done", ALL | BUSYB);
        clear_inputs();
        step("md2_idle", ALL);

        // Stray done in IDLE is ignored
        muldiv_done = 1;
        step("stray_done", ALL);
        muldiv_done = 0;
        step("stray_done_after", ALL);

        // Start and done together: single-cycle handoff, stays IDLE
        ex_muldiv_start = 1; muldiv_done = 1;
        step("md_same_cycle", ALL);
        clear_inputs();
        step("md_same_cycle_after", ALL);

        // Reset mid-BUSY
        ex_muldiv_start = 1;
        step("rb_c0", MD);
        step("rb_c1", MD | BUSYB);
        rst = 1;
        step("rb_rst", FREEZE);
        rst = 0; ex_muldiv_start = 0;
        step("rb_after", ALL);
        chk_cnt("rb_counters", 32'd0, 32'd0);

        // Performance counters
        rst = 1;
        step("perf_rst", FREEZE);
        rst = 0;
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9;
        for (int i = 0; i < 10; i++) step("perf_lu", LU);
        clear_inputs();
        br_taken = 1;
        for (int i = 0; i < 3; i++) step("perf_br", BRV);
        clear_inputs();
        chk_cnt("perf_counts", EXP_STALL, EXP_FLUSH);

`ifdef HAZARD_PERF_EN
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9;
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        force dut.flush_count_q  = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.stall_cycles_q;
        release dut.flush_count_q;
        step("sat_lu", LU);
        clear_inputs();
        br_taken = 1;
        step("sat_br", BRV);
        clear_inputs();
        chk_cnt("sat_counts", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
